// File: rtl/spi_duty_slave.sv
// SPI mode-0 slave holding DUTY/CTRL/ID registers; drives the PWM comparator value comp.
// Latency: wr_strobe one clkin after the 16th synced SCK rise, comp one clkin later (SPI_DUTY_FADE_EN: ramped).
// Backpressure: none, the SPI host paces all traffic; f_sck must stay <= f_clkin/4.
module spi_duty_slave #(
    parameter logic [7:0]  DEFAULT_DUTY = 8'd0,
`ifdef SPI_DUTY_FADE_EN
    parameter int unsigned FADE_DIV     = 1024,
`endif
    parameter logic [7:0]  ID_VALUE     = 8'hA5
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] comp,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] miso_sh;
    logic [7:0] duty_q;
    logic       ctrl_en;

    // Address and data as they stand once the current rise's MOSI bit is appended.
    logic [6:0] addr_nxt;
    logic [7:0] data_nxt;
    logic [7:0] rd_data;
    assign addr_nxt = {shift_in[5:0], mosi_s2};
    assign data_nxt = {shift_in, mosi_s2};

    always_comb begin
        rd_data = 8'h00;
        case (addr_nxt)
            7'h00:   rd_data = duty_q;
            7'h01:   rd_data = {7'b0, ctrl_en};
            7'h02:   rd_data = ID_VALUE;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= 7'd0;
            miso_sh   <= 8'd0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            duty_q    <= DEFAULT_DUTY;
            ctrl_en   <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (cs_rise) begin
                state    <= IDLE;
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= 3'd0;
                            spi_miso <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[5:0], mosi_s2};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                cmd_rw   <= shift_in[6];
                                cmd_addr <= addr_nxt;
                                state    <= DATA;
                                if (!shift_in[6]) begin
                                    miso_sh  <= rd_data;
                                    spi_miso <= rd_data[7];
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[5:0], mosi_s2};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= DONE;
                                if (cmd_rw) begin
                                    case (cmd_addr)
                                        7'h00: begin
                                            duty_q    <= data_nxt;
                                            wr_strobe <= 1'b1;
                                        end
                                        7'h01: begin
                                            ctrl_en   <= data_nxt[0];
                                            wr_strobe <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        // The fall right after the 8th rise must not shift: bit7 is held for the 9th rise.
                        end else if (sck_fall && !cmd_rw && bit_cnt != 3'd0) begin
                            miso_sh  <= {miso_sh[6:0], 1'b0};
                            spi_miso <= miso_sh[6];
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [7:0] comp_tgt;
    assign comp_tgt = ctrl_en ? duty_q : 8'd0;

`ifdef SPI_DUTY_FADE_EN
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    assign tick = (presc == PW'(FADE_DIV - 1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            comp  <= 8'd0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                if (comp < comp_tgt)
                    comp <= comp + 8'd1;
                else if (comp > comp_tgt)
                    comp <= comp - 8'd1;
            end
        end
    end
`else
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)
            comp <= 8'd0;
        else
            comp <= comp_tgt;
    end
`endif

endmodule

// File: tb/tb_spi_duty_slave.sv
// Directed bench for spi_duty_slave: table of SPI frames plus reset and fade sequences.
module tb_spi_duty_slave;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] comp;
    logic       wr_strobe;

    always #5 clkin = ~clkin;

    spi_duty_slave #(
        .DEFAULT_DUTY(8'h5C),
`ifdef SPI_DUTY_FADE_EN
        .FADE_DIV(4),
`endif
        .ID_VALUE(8'hA5)
    ) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .comp     (comp),
        .wr_strobe(wr_strobe)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors on the falling edge, away from the active clkin edge.
    int         cyc = 0;
    int         strobe_cycles = 0;
    int         strobe_pulses = 0;
    logic       strobe_prev = 1'b0;
    logic [7:0] comp_at_strobe = 8'h00;
    logic [7:0] comp_after_strobe = 8'h00;
    logic [7:0] last_comp = 8'h00;
    logic [7:0] chg_val[$];
    int         chg_cyc[$];

    always @(negedge clkin) begin
        cyc++;
        if (strobe_prev) comp_after_strobe = comp;
        if (wr_strobe) begin
            strobe_cycles++;
            comp_at_strobe = comp;
            if (!strobe_prev) strobe_pulses++;
        end
        strobe_prev = wr_strobe;
        if (comp !== last_comp) begin
            chg_val.push_back(comp);
            chg_cyc.push_back(cyc);
            last_comp = comp;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // One frame: nbits SCK periods (8 clkin each); MISO sampled just before each data-phase rise.
    task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        spi_cs_n = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 16) ? word[15-i] : 1'b1;
            wait_cyc(4);
            if (i >= 8 && i < 16) rx[15-i] = spi_miso;
            spi_sck = 1'b1;
            wait_cyc(4);
            spi_sck = 1'b0;
        end
        wait_cyc(8);
        spi_cs_n = 1'b1;
        wait_cyc(8);
    endtask

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [7:0]  exp_rx;
        int          exp_strb;
        logic [7:0]  exp_comp;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [7:0] rx;
        int         p0;
        int         exp_strb_total;
        exp_strb_total = 0;

        vecs[0]  = '{16'h0000, 16, 8'h5C, 0, 8'h00};
        vecs[1]  = '{16'h8040, 16, 8'h00, 1, 8'h00};
        vecs[2]  = '{16'h8101, 16, 8'h00, 1, 8'h40};
        vecs[3]  = '{16'h0200, 16, 8'hA5, 0, 8'h40};
        vecs[4]  = '{16'h7F00, 16, 8'h00, 0, 8'h40};
        vecs[5]  = '{16'h8200, 16, 8'h00, 0, 8'h40};
        vecs[6]  = '{16'h0200, 16, 8'hA5, 0, 8'h40};
        vecs[7]  = '{16'h80FF, 12, 8'h00, 0, 8'h40};
        vecs[8]  = '{16'h0000, 16, 8'h40, 0, 8'h40};
        vecs[9]  = '{16'h80FF, 16, 8'h00, 1, 8'hFF};
        vecs[10] = '{16'h8100, 16, 8'h00, 1, 8'h00};
        vecs[11] = '{16'h0100, 16, 8'h00, 0, 8'h00};
        vecs[12] = '{16'h81FF, 16, 8'h00, 1, 8'hFF};
        vecs[13] = '{16'h0100, 16, 8'h01, 0, 8'hFF};
        vecs[14] = '{16'h8000, 16, 8'h00, 1, 8'h00};
        vecs[15] = '{16'h8512, 16, 8'h00, 0, 8'h00};
        vecs[16] = '{16'h0500, 16, 8'h00, 0, 8'h00};
        vecs[17] = '{16'h8011, 20, 8'h00, 1, 8'h11};
        vecs[18] = '{16'h0000, 16, 8'h11, 0, 8'h11};
        vecs[19] = '{16'h80BC, 16, 8'h00, 1, 8'hBC};

        wait_cyc(3);
        chk("reset comp", {24'h0, comp}, 32'h00);
        chk("reset miso", {31'h0, spi_miso}, 32'h0);
        chk("reset wr_strobe", {31'h0, wr_strobe}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5);
        chk("post-reset comp", {24'h0, comp}, 32'h00);

        for (int i = 0; i < 20; i++) begin
            p0 = strobe_pulses;
            spi_frame(vecs[i].word, vecs[i].nbits, rx);
`ifdef SPI_DUTY_FADE_EN
            wait_cyc(1100);
`endif
            exp_strb_total += vecs[i].exp_strb;
            chk($sformatf("vec%0d rx", i), {24'h0, rx}, {24'h0, vecs[i].exp_rx});
            chk($sformatf("vec%0d strobes", i), strobe_pulses - p0, vecs[i].exp_strb);
            chk($sformatf("vec%0d comp", i), {24'h0, comp}, {24'h0, vecs[i].exp_comp});
`ifndef SPI_DUTY_FADE_EN
            if (i == 2) begin
                chk("comp at enable strobe", {24'h0, comp_at_strobe}, 32'h00);
                chk("comp one cycle after strobe", {24'h0, comp_after_strobe}, 32'h40);
            end
`endif
        end
        chk("strobe cycles one per write", strobe_cycles, exp_strb_total);

        // Reset in the middle of a read of DUTY (0xBC): MISO shows bit7 before the reset.
        spi_cs_n = 1'b0;
        spi_mosi = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 9; i++) begin
            wait_cyc(4);
            if (i == 8) chk("mid-read miso bit7", {31'h0, spi_miso}, 32'h1);
            spi_sck = 1'b1;
            wait_cyc(4);
            spi_sck = 1'b0;
        end
        wait_cyc(2);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("midrst comp", {24'h0, comp}, 32'h00);
        chk("midrst miso", {31'h0, spi_miso}, 32'h0);
        chk("midrst wr_strobe", {31'h0, wr_strobe}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(4);
        spi_cs_n = 1'b1;
        wait_cyc(8);
        spi_frame(16'h0000, 16, rx);
        chk("midrst DUTY default", {24'h0, rx}, 32'h5C);
        spi_frame(16'h0100, 16, rx);
        chk("midrst CTRL cleared", {24'h0, rx}, 32'h00);
        chk("midrst comp stays 0", {24'h0, comp}, 32'h00);

`ifdef SPI_DUTY_FADE_EN
        spi_frame(16'h8003, 16, rx);
        wait_cyc(20);
        chk("fade comp idle while EN=0", {24'h0, comp}, 32'h00);
        chg_val.delete();
        chg_cyc.delete();
        spi_frame(16'h8101, 16, rx);
        wait_cyc(60);
        chk("fade step count", chg_val.size(), 3);
        if (chg_val.size() == 3) begin
            chk("fade step1", {24'h0, chg_val[0]}, 32'h01);
            chk("fade step2", {24'h0, chg_val[1]}, 32'h02);
            chk("fade step3", {24'h0, chg_val[2]}, 32'h03);
            chk("fade interval1", chg_cyc[1] - chg_cyc[0], 4);
            chk("fade interval2", chg_cyc[2] - chg_cyc[1], 4);
        end
        chk("fade hold", {24'h0, comp}, 32'h03);
        spi_frame(16'h8100, 16, rx);
        wait_cyc(40);
        chk("fade down to 0", {24'h0, comp}, 32'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
